// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and constants.
//   float32_t - IEEE-754 single-precision fields (sign/exp/frac)
//   ext_sig_t - 27-bit extended significand {carry, hidden, frac[22:0], guard, round}
//   EXP_MAX, FRAC_W, ALIGN_CLAMP - format and alignment constants
package fpu_pkg;

    localparam int unsigned FRAC_W      = 23;
    localparam logic [7:0]  EXP_MAX     = 8'd255;
    localparam logic [4:0]  ALIGN_CLAMP = 5'd31;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    typedef logic [26:0] ext_sig_t;

endpackage

// File: rtl/fsub_lzc.sv
// fsub_lzc: combinational leading-zero counter over a 27-bit extended significand.
//   din   in  27  value to scan (bit 26 is the MSB)
//   count out  5  number of leading zeros, saturating at 26 (26 also means all-zero)
module fsub_lzc
    import fpu_pkg::*;
(
    input  ext_sig_t   din,
    output logic [4:0] count
);

    // Ascending scan: the highest set bit is visited last and therefore wins.
    always_comb begin
        count = 5'd26;
        for (int unsigned i = 0; i < 27; i++) begin
            if (din[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fsub_pipe.sv
// fsub_pipe: pipelined IEEE-754 single-precision subtractor, y = x1 - x2.
// Flush-to-zero inputs, round-to-nearest-even, overflow flag.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake, operands x1 (minuend), x2 (subtrahend)
//   out_valid/out_ready  result handshake, y (result), ovf (overflow, qualified by out_valid)
// Build option FSUB_PIPE_S3_EN:
//   defined   - S1 (align) / S2 (add, normalize) / S3 (round, pack), latency 3
//   undefined - S2 and S3 merged into one register stage, latency 2
module fsub_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [25:0] big;
        logic [25:0] sml;
        logic        sticky;
        logic        sub;
        logic        zero_both;
        logic        zero_sign;
        logic        inf_in;
    } s1_t;

    // man[25] is the hidden bit; it is cleared whenever the result is zero.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [25:0] man;
        logic        sticky;
        logic        zero_sign;
        logic        inf_in;
    } s2_t;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
    } res_t;

    function automatic res_t round_pack(input s2_t s);
        logic       rup;
        logic [23:0] fr;
        logic [9:0] e;
        res_t       r;
        rup = s.man[1] & (s.man[0] | s.sticky | s.man[2]);
        fr  = {1'b0, s.man[24:2]} + {23'b0, rup};
        e   = s.exp + {9'b0, fr[23]};
        r.ovf = 1'b0;
        if (!s.man[25]) begin
            r.y = {s.zero_sign, 31'b0};
        end else if (e >= {2'b00, EXP_MAX} && !s.inf_in) begin
            r.y   = {s.sign, EXP_MAX, 23'b0};
            r.ovf = 1'b1;
        end else begin
            r.y = {s.sign, e[7:0], fr[22:0]};
        end
        return r;
    endfunction

    // ---------------- S1: unpack, compare, align ----------------
    float32_t    fa, fb;
    logic        za, zb, a_big;
    logic [30:0] mag_a, mag_b;
    logic [25:0] sig_a, sig_b, sml_sig;
    logic [7:0]  exp_a, exp_b, sml_exp, exp_diff;
    logic [4:0]  shamt;
    logic [56:0] wide;
    s1_t         s1_n;

    always_comb begin
        fa      = x1;
        fb      = x2;
        fb.sign = ~x2[31];
        za      = (fa.exp == 8'd0);
        zb      = (fb.exp == 8'd0);
        exp_a   = za ? 8'd0 : fa.exp;
        exp_b   = zb ? 8'd0 : fb.exp;
        sig_a   = za ? 26'd0 : {1'b1, fa.frac, 2'b00};
        sig_b   = zb ? 26'd0 : {1'b1, fb.frac, 2'b00};
        mag_a   = za ? 31'd0 : {fa.exp, fa.frac};
        mag_b   = zb ? 31'd0 : {fb.exp, fb.frac};
        a_big   = (mag_a >= mag_b);

        s1_n = '0;
        if (a_big) begin
            s1_n.sign = fa.sign;
            s1_n.exp  = exp_a;
            s1_n.big  = sig_a;
            sml_sig   = sig_b;
            sml_exp   = exp_b;
        end else begin
            s1_n.sign = fb.sign;
            s1_n.exp  = exp_b;
            s1_n.big  = sig_b;
            sml_sig   = sig_a;
            sml_exp   = exp_a;
        end

        exp_diff = s1_n.exp - sml_exp;
        shamt    = (exp_diff > {3'b0, ALIGN_CLAMP}) ? ALIGN_CLAMP : exp_diff[4:0];
        // Shift into a wide window so everything shifted out lands in the low 31 bits.
        wide           = {sml_sig, 31'b0} >> shamt;
        s1_n.sml       = wide[56:31];
        s1_n.sticky    = |wide[30:0];
        s1_n.sub       = fa.sign ^ fb.sign;
        s1_n.zero_both = za & zb;
        s1_n.zero_sign = fa.sign & fb.sign;
        s1_n.inf_in    = (fa.exp == EXP_MAX) || (fb.exp == EXP_MAX);
    end

    // ---------------- S2: add, LZC, normalize ----------------
    logic        v1_q, v1_d;
    s1_t         s1_q, s1_d;
    ext_sig_t    sum;
    logic [4:0]  lz, shift;
    s2_t         s2_n;

    fsub_lzc u_lzc (
        .din   (sum),
        .count (lz)
    );

    always_comb begin
        sum = s1_q.sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.sml})
                       : ({1'b0, s1_q.big} + {1'b0, s1_q.sml});
        // Without a carry the normalized hidden bit sits at bit 25, one below the MSB.
        shift          = lz - 5'd1;
        s2_n           = '0;
        s2_n.sign      = s1_q.sign;
        s2_n.zero_sign = s1_q.zero_both & s1_q.zero_sign;
        s2_n.inf_in    = s1_q.inf_in;
        if (sum[26]) begin
            s2_n.man    = sum[26:1];
            s2_n.sticky = s1_q.sticky | sum[0];
            s2_n.exp    = {2'b00, s1_q.exp} + 10'd1;
        end else begin
            s2_n.man    = sum[25:0] << shift;
            s2_n.sticky = s1_q.sticky;
            s2_n.exp    = {2'b00, s1_q.exp} - {5'b0, shift};
            if (sum == '0 || ({2'b00, s1_q.exp} <= {5'b0, shift})) begin
                s2_n.man = '0;
            end
        end
    end

    // ---------------- pipeline control / S3 ----------------
    logic v2_q, v2_d;
    logic s2_accept;
    res_t res_q, res_d;
`ifdef FSUB_PIPE_S3_EN
    logic v3_q, v3_d;
    logic s3_accept;
    s2_t  s2_q, s2_d;
`endif

    always_comb begin
`ifdef FSUB_PIPE_S3_EN
        s3_accept = !v3_q || out_ready;
        s2_accept = !v2_q || s3_accept;
`else
        s2_accept = !v2_q || out_ready;
`endif
        in_ready = !v1_q || s2_accept;
        v1_d     = in_ready ? in_valid : v1_q;
        s1_d     = (in_ready && in_valid) ? s1_n : s1_q;
        v2_d     = s2_accept ? v1_q : v2_q;
`ifdef FSUB_PIPE_S3_EN
        s2_d  = (s2_accept && v1_q) ? s2_n : s2_q;
        v3_d  = s3_accept ? v2_q : v3_q;
        res_d = (s3_accept && v2_q) ? round_pack(s2_q) : res_q;
`else
        res_d = (s2_accept && v1_q) ? round_pack(s2_n) : res_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            s1_q  <= '0;
            v2_q  <= 1'b0;
            res_q <= '0;
`ifdef FSUB_PIPE_S3_EN
            v3_q  <= 1'b0;
            s2_q  <= '0;
`endif
        end else begin
            v1_q  <= v1_d;
            s1_q  <= s1_d;
            v2_q  <= v2_d;
            res_q <= res_d;
`ifdef FSUB_PIPE_S3_EN
            v3_q  <= v3_d;
            s2_q  <= s2_d;
`endif
        end
    end

`ifdef FSUB_PIPE_S3_EN
    assign out_valid = v3_q;
`else
    assign out_valid = v2_q;
`endif
    assign y   = res_q.y;
    assign ovf = res_q.ovf;

endmodule
